tag_lookup_ctrl: RTL and testbench

TAG_LOOKUP_CTRL -- requirements
Module: tag_lookup_ctrl

---
 rtl/tag_lookup_ctrl.sv | 137 +++++++++++++
 tb/tb_tag_lookup_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/tag_lookup_ctrl.sv
// rtl/tag_lookup_ctrl.sv - tag RAM lookup/allocate controller with power-on and on-demand flush
//
// Ports:
//   clock, reset_n      : single rising-edge clock, asynchronous active-low reset
//   flush               : one-cycle request to invalidate every tag RAM entry (honoured in IDLE only)
//   req_valid/req_ready : lookup request handshake; req_addr = {tag, index}, req_wr = write/allocate
//   resp_valid/resp_hit : one-cycle response strobe and hit result
//   ram_addr/ram_din/ram_we/ram_dout : synchronous-read tag RAM port (dout one cycle after addr)
module tag_lookup_ctrl #(
  parameter int AWIDTH = 3,
  parameter int DWIDTH = 14,
  localparam int TWIDTH = DWIDTH - 1,
  localparam int DEPTH  = 2 ** AWIDTH
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [TWIDTH+AWIDTH-1:0] req_addr,
  input  logic                     req_wr,
  output logic                     resp_valid,
  output logic                     resp_hit,
  output logic [AWIDTH-1:0]        ram_addr,
  output logic [DWIDTH-1:0]        ram_din,
  output logic                     ram_we,
  input  logic [DWIDTH-1:0]        ram_dout
);

  typedef enum logic [2:0] {
    INIT,
    FLUSH,
    IDLE,
    ISSUE,
    COMPARE,
    ALLOC,
    RESP
  } state_t;

  state_t              state_q, state_d;
  logic [AWIDTH-1:0]   cnt_q, cnt_d;
  logic [TWIDTH-1:0]   tag_q, tag_d;
  logic [AWIDTH-1:0]   idx_q, idx_d;
  logic                wr_q, wr_d;
  logic                hit_q, hit_d;
  logic                cmp_hit;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= INIT;
      cnt_q   <= '0;
      tag_q   <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tag_q   <= tag_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      hit_q   <= hit_d;
    end
  end

  // RAM data for the captured index is on ram_dout while in COMPARE.
  assign cmp_hit = ram_dout[DWIDTH-1] && (ram_dout[TWIDTH-1:0] == tag_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tag_d   = tag_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    hit_d   = hit_q;
    case (state_q)
      INIT: begin
        state_d = FLUSH;
        cnt_d   = '0;
      end
      FLUSH: begin
        // flush is deliberately not looked at here so the sweep is never restarted.
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == AWIDTH'(DEPTH - 1)) state_d = IDLE;
      end
      IDLE: begin
        if (flush) begin
          state_d = FLUSH;
          cnt_d   = '0;
        end else if (req_valid) begin
          state_d = ISSUE;
          tag_d   = req_addr[TWIDTH+AWIDTH-1:AWIDTH];
          idx_d   = req_addr[AWIDTH-1:0];
          wr_d    = req_wr;
        end
      end
      ISSUE:   state_d = COMPARE;
      COMPARE: begin
        hit_d   = cmp_hit;
        state_d = (wr_q && !cmp_hit) ? ALLOC : RESP;
      end
      ALLOC:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = INIT;
    endcase
  end

  // Outputs come from registered state; only req_ready also sees flush so that
  // a simultaneous flush and request leaves the request unaccepted.
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_hit   = 1'b0;
    ram_addr   = '0;
    ram_din    = '0;
    ram_we     = 1'b0;
    case (state_q)
      FLUSH: begin
        ram_we   = 1'b1;
        ram_addr = cnt_q;
      end
      IDLE:  req_ready = !flush;
      ISSUE: ram_addr = idx_q;
      ALLOC: begin
        ram_we   = 1'b1;
        ram_addr = idx_q;
        ram_din  = {1'b1, tag_q};
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_hit   = hit_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_tag_lookup_ctrl.sv
// tb/tb_tag_lookup_ctrl.sv - directed self-checking bench for tag_lookup_ctrl
module tb_tag_lookup_ctrl;

  localparam int AWIDTH = 3;
  localparam int DWIDTH = 14;
  localparam int TWIDTH = DWIDTH - 1;

  logic                     clock;
  logic                     reset_n;
  logic                     flush;
  logic                     req_valid;
  logic                     req_ready;
  logic [TWIDTH+AWIDTH-1:0] req_addr;
  logic                     req_wr;
  logic                     resp_valid;
  logic                     resp_hit;
  logic [AWIDTH-1:0]        ram_addr;
  logic [DWIDTH-1:0]        ram_din;
  logic                     ram_we;
  logic [DWIDTH-1:0]        ram_dout;

  logic [DWIDTH-1:0] mem [0:(1<<AWIDTH)-1];

  int total = 0;
  int bad   = 0;

  tag_lookup_ctrl #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_wr     (req_wr),
    .resp_valid (resp_valid),
    .resp_hit   (resp_hit),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .ram_we     (ram_we),
    .ram_dout   (ram_dout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous-read tag RAM, starting with junk so a missing flush shows up as a hit.
  initial begin
    for (int i = 0; i < (1 << AWIDTH); i++) mem[i] = {1'b1, 13'h0055};
    ram_dout = '0;
  end
  always @(posedge clock) begin
    ram_dout <= mem[ram_addr];
    if (ram_we) mem[ram_addr] <= ram_din;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Counts ram_we cycles from now until req_ready; checks address sequence and data.
  task automatic flush_check(input string tag, input int flush_hold);
    int n;
    int seen_resp;
    n = 0;
    seen_resp = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clock);
      if (k >= flush_hold) flush = 1'b0;
      if (resp_valid) seen_resp = 1;
      if (ram_we) begin
        chk({tag, "_addr"}, 32'(ram_addr), 32'(n));
        chk({tag, "_din"}, 32'(ram_din), 32'h0);
        n++;
      end else if (n > 0 && !req_ready) begin
        chk({tag, "_gap"}, 32'(ram_we), 32'h1);
      end
      if (req_ready) break;
    end
    chk({tag, "_count"}, 32'(n), 32'd8);
    chk({tag, "_ready"}, 32'(req_ready), 32'h1);
    chk({tag, "_noresp"}, 32'(seen_resp), 32'h0);
  endtask

  // Presents one request from IDLE and checks latency, hit and RAM writes.
  task automatic do_req(input string tag, input logic [15:0] addr, input logic wr,
                        input logic exp_hit, input int exp_lat, input int exp_writes,
                        input logic [13:0] exp_din, input int flush_at);
    int lat;
    int writes;
    logic [AWIDTH-1:0] waddr;
    logic [DWIDTH-1:0] wdin;
    lat = 0;
    writes = 0;
    waddr = '0;
    wdin = '0;
    @(negedge clock);
    chk({tag, "_ready"}, 32'(req_ready), 32'h1);
    req_valid = 1'b1;
    req_addr  = addr;
    req_wr    = wr;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      req_valid = 1'b0;
      flush = (k == flush_at);
      if (ram_we) begin
        writes++;
        waddr = ram_addr;
        wdin  = ram_din;
      end
      if (resp_valid) begin
        lat = k;
        chk({tag, "_hit"}, 32'(resp_hit), 32'(exp_hit));
        break;
      end
    end
    flush = 1'b0;
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_writes"}, 32'(writes), 32'(exp_writes));
    if (exp_writes > 0) begin
      chk({tag, "_waddr"}, 32'(waddr), 32'(addr[2:0]));
      chk({tag, "_wdin"}, 32'(wdin), 32'(exp_din));
    end
    @(negedge clock);
    chk({tag, "_pulse"}, 32'(resp_valid), 32'h0);
    chk({tag, "_idle"}, 32'(req_ready), 32'h1);
  endtask

  initial begin
    int n;
    int seen;
    reset_n   = 1'b0;
    flush     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_wr    = 1'b0;

    repeat (3) @(negedge clock);
    chk("rst_we", 32'(ram_we), 32'h0);
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_resp", 32'(resp_valid), 32'h0);
    chk("rst_addr", 32'(ram_addr), 32'h0);
    reset_n = 1'b1;
    flush_check("pwr_flush", 0);

    do_req("rd_miss",   16'h02AA, 1'b0, 1'b0, 3, 0, 14'h0000, 0);
    do_req("wr_miss",   16'h02AA, 1'b1, 1'b0, 4, 1, 14'h2055, 0);
    do_req("rd_hit",    16'h02AA, 1'b0, 1'b1, 3, 0, 14'h0000, 0);
    do_req("wr_hit",    16'h02AA, 1'b1, 1'b1, 3, 0, 14'h0000, 0);
    do_req("wr_repl",   16'h03BA, 1'b1, 1'b0, 4, 1, 14'h2077, 0);
    do_req("rd_old",    16'h02AA, 1'b0, 1'b0, 3, 0, 14'h0000, 0);
    do_req("rd_new_fl", 16'h03BA, 1'b0, 1'b1, 3, 0, 14'h0000, 1);

    // flush and request together: flush wins, request waits, flush held to test no restart
    @(negedge clock);
    flush     = 1'b1;
    req_valid = 1'b1;
    req_addr  = 16'h03BA;
    req_wr    = 1'b0;
    #1;
    chk("fl_req_ready", 32'(req_ready), 32'h0);
    flush_check("req_flush", 3);
    n = 0;
    seen = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      req_valid = 1'b0;
      if (resp_valid) begin
        n = k;
        seen = 1;
        chk("fl_req_hit", 32'(resp_hit), 32'h0);
        break;
      end
    end
    chk("fl_req_lat", 32'(n), 32'd3);

    // reset while in ALLOC
    @(negedge clock);
    req_valid = 1'b1;
    req_addr  = 16'h008D;
    req_wr    = 1'b1;
    seen = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      req_valid = 1'b0;
      if (ram_we) begin
        seen = k;
        break;
      end
    end
    chk("alloc_reached", 32'(seen), 32'd3);
    #2 reset_n = 1'b0;
    #1;
    chk("alloc_rst_we", 32'(ram_we), 32'h0);
    chk("alloc_rst_resp", 32'(resp_valid), 32'h0);
    seen = 0;
    repeat (2) begin
      @(negedge clock);
      if (resp_valid) seen = 1;
    end
    reset_n = 1'b1;
    chk("alloc_rst_noresp", 32'(seen), 32'h0);
    flush_check("rst_flush", 0);
    do_req("rd_after_rst", 16'h008D, 1'b0, 1'b0, 3, 0, 14'h0000, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
